// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants and encodings for the register-file write-port arbiter.
// Covers the x0 index, the zero word, the sweep FSM states and the grant encodings.
package reg_wr_arbiter_pkg;

  localparam int          X0        = 0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    GNT_WB = 1'b0,
    GNT_LD = 1'b1
  } gnt_t;

endpackage

// File: rtl/reg_wr_arbiter_wr_port_arb.sv
// Combinational Ready generation for the writeback and load-return requesters.
// Optional round-robin (macro REG_WR_ARB_RR_EN) keeps its LastGnt register here.
module wr_port_arb
  import reg_wr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic wb_valid,
  input  logic ld_valid,
  output logic wb_ready,
  output logic ld_ready
);

`ifdef REG_WR_ARB_RR_EN
  gnt_t last_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= GNT_LD;
    end else if (wb_valid && wb_ready) begin
      last_gnt <= GNT_WB;
    end else if (ld_valid && ld_ready) begin
      last_gnt <= GNT_LD;
    end
  end

  // A side only loses when the other side is also valid and it was granted last.
  always_comb begin
    wb_ready = run && !(ld_valid && (last_gnt == GNT_WB));
    ld_ready = run && !(wb_valid && (last_gnt == GNT_LD));
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    wb_ready = run;
    ld_ready = run && !wb_valid;
  end
`endif

endmodule

// File: rtl/reg_wr_arbiter.sv
// Single write port of the GPR file: zero-fill sweep of x1..x(NUM_REGS-1) after reset,
// then Wb/Ld arbitration. Round-robin grant is enabled by defining REG_WR_ARB_RR_EN.
module reg_wr_arbiter
  import reg_wr_arbiter_pkg::*;
#(
  parameter int                NUM_REGS   = 32,
  parameter int                ADDR_W     = $clog2(NUM_REGS),
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(ZERO_WORD)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WbValid,
  output logic              WbReady,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  input  logic              LdValid,
  output logic              LdReady,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] AddrRd,
  output logic [DATA_W-1:0] WrData,
  output logic              InitDone
);

  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ADDR_X0   = ADDR_W'(X0);
  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              run;
  logic              wb_xfer_p0, ld_xfer_p0;

  logic              vld_p0, done_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1, done_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  assign run = (state == ST_RUN);

  wr_port_arb u_arb (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .run      (run),
    .wb_valid (WbValid),
    .ld_valid (LdValid),
    .wb_ready (WbReady),
    .ld_ready (LdReady)
  );

  assign wb_xfer_p0 = WbValid && WbReady;
  assign ld_xfer_p0 = LdValid && LdReady;

  // Stage p0: next-state and write selection; transfers to x0 are consumed but never issued.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vld_p0    = 1'b0;
    addr_p0   = addr_p1;
    data_p0   = data_p1;
    done_p0   = done_p1;
    unique case (state)
      ST_INIT: begin
        vld_p0  = 1'b1;
        addr_p0 = cnt;
        data_p0 = INIT_VALUE;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_REG) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        done_p0 = 1'b1;
        if (wb_xfer_p0 && (WbAddr != ADDR_X0)) begin
          vld_p0  = 1'b1;
          addr_p0 = WbAddr;
          data_p0 = WbData;
        end else if (ld_xfer_p0 && (LdAddr != ADDR_X0)) begin
          vld_p0  = 1'b1;
          addr_p0 = LdAddr;
          data_p0 = LdData;
        end
      end
    endcase
  end

  // Stage p1: registered register-file pins and sweep state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_INIT;
      cnt     <= FIRST_REG;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      done_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vld_p1  <= vld_p0;
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
      done_p1 <= done_p0;
    end
  end

  assign RegWrite = vld_p1;
  assign AddrRd   = addr_p1;
  assign WrData   = data_p1;
  assign InitDone = done_p1;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus randomized traffic
// against a rule-level model of grant, latency and register-file contents.
module tb_reg_wr_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  logic              Clk     = 1'b0;
  logic              Rst_n   = 1'b0;
  logic              WbValid = 1'b0;
  logic              WbReady;
  logic [ADDR_W-1:0] WbAddr  = '0;
  logic [DATA_W-1:0] WbData  = '0;
  logic              LdValid = 1'b0;
  logic              LdReady;
  logic [ADDR_W-1:0] LdAddr  = '0;
  logic [DATA_W-1:0] LdData  = '0;
  logic              RegWrite;
  logic [ADDR_W-1:0] AddrRd;
  logic [DATA_W-1:0] WrData;
  logic              InitDone;

  reg_wr_arbiter #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .INIT_VALUE (32'h0)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .WbValid  (WbValid),
    .WbReady  (WbReady),
    .WbAddr   (WbAddr),
    .WbData   (WbData),
    .LdValid  (LdValid),
    .LdReady  (LdReady),
    .LdAddr   (LdAddr),
    .LdData   (LdData),
    .RegWrite (RegWrite),
    .AddrRd   (AddrRd),
    .WrData   (WrData),
    .InitDone (InitDone)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  // Model state: run phase, last granted side (1 = Ld), expected output pins, register file.
  logic              m_run  = 1'b0;
`ifdef REG_WR_ARB_RR_EN
  logic              m_last = 1'b1;
`endif
  logic              e_rw   = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  logic [DATA_W-1:0] ref_rf [NUM_REGS];
  logic [DATA_W-1:0] tb_rf  [NUM_REGS];

  // Expected {WbReady, LdReady}: a side is held off only when the other is valid and wins.
  function automatic logic [1:0] exp_rdy(input logic wbv, input logic ldv);
    logic ld_beats_wb, wb_beats_ld;
`ifdef REG_WR_ARB_RR_EN
    ld_beats_wb = (m_last == 1'b0);
    wb_beats_ld = (m_last == 1'b1);
`else
    ld_beats_wb = 1'b0;
    wb_beats_ld = 1'b1;
`endif
    return {m_run && !(ldv && ld_beats_wb), m_run && !(wbv && wb_beats_ld)};
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
`ifdef REG_WR_ARB_RR_EN
    m_last = 1'b1;
`endif
    e_rw   = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    WbValid = 1'b1;
    LdValid = 1'b1;
    @(posedge Clk);
    #1;
    model_reset();
    checks++;
    if ({RegWrite, AddrRd, WrData, InitDone} !== {1'b0, 5'd0, 32'd0, 1'b0})
      $display("FAIL reset_outputs: got rw=%b addr=%0d data=%h done=%b, want all zero",
               RegWrite, AddrRd, WrData, InitDone);
    else passed++;
    checks++;
    if ({WbReady, LdReady} !== 2'b00)
      $display("FAIL reset_ready: got %b, want 00", {WbReady, LdReady});
    else passed++;
    WbValid = 1'b0;
    LdValid = 1'b0;
    release_reset();
  endtask

  task automatic test_init_sweep();
    for (int k = 1; k <= 31; k++) begin
      checks++;
      if ({WbReady, LdReady} !== 2'b00)
        $display("FAIL init_ready before edge %0d: got %b, want 00", k, {WbReady, LdReady});
      else passed++;
      @(posedge Clk);
      #1;
      checks++;
      if ({RegWrite, AddrRd, WrData, InitDone} !== {1'b1, 5'(k), 32'd0, 1'b0})
        $display("FAIL init_write cycle %0d: got rw=%b addr=%0d data=%h done=%b, want rw=1 addr=%0d data=0 done=0",
                 k, RegWrite, AddrRd, WrData, InitDone, k);
      else passed++;
    end
    m_run  = 1'b1;
    e_addr = 5'd31;
    e_data = 32'd0;
    e_rw   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ref_rf[i] = 32'd0;
      tb_rf[i]  = 32'd0;
    end
    checks++;
    if ({WbReady, LdReady} !== 2'b11)
      $display("FAIL run_ready_idle: got %b, want 11", {WbReady, LdReady});
    else passed++;
    @(posedge Clk);
    #1;
    checks++;
    if ({RegWrite, AddrRd, InitDone} !== {1'b0, 5'd31, 1'b1})
      $display("FAIL init_done cycle 32: got rw=%b addr=%0d done=%b, want rw=0 addr=31 done=1",
               RegWrite, AddrRd, InitDone);
    else passed++;
  endtask

  task automatic test_wb_single();
    WbValid = 1'b1;
    WbAddr  = 5'd5;
    WbData  = 32'hDEADBEEF;
    LdValid = 1'b0;
    #1;
    checks++;
    if (WbReady !== 1'b1) $display("FAIL wb_single_ready: got %b, want 1", WbReady);
    else passed++;
`ifdef REG_WR_ARB_RR_EN
    m_last = 1'b0;
`endif
    @(posedge Clk);
    #1;
    WbValid = 1'b0;
    checks++;
    if ({RegWrite, AddrRd, WrData} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL wb_single_write: got rw=%b addr=%0d data=%h, want rw=1 addr=5 data=deadbeef",
               RegWrite, AddrRd, WrData);
    else passed++;
    ref_rf[5] = 32'hDEADBEEF;
    if (RegWrite === 1'b1) tb_rf[AddrRd] = WrData;
    e_addr = 5'd5;
    e_data = 32'hDEADBEEF;
    @(posedge Clk);
    #1;
    checks++;
    if ({RegWrite, AddrRd, WrData} !== {1'b0, 5'd5, 32'hDEADBEEF})
      $display("FAIL wb_single_hold: got rw=%b addr=%0d data=%h, want rw=0 addr=5 data=deadbeef",
               RegWrite, AddrRd, WrData);
    else passed++;
  endtask

  task automatic test_same_addr();
    logic              wb_p = 1'b1, ld_p = 1'b1;
    logic [1:0]        r;
    logic              wb_go, ld_go;
    logic [DATA_W-1:0] first_data = '0;
    int                nwr = 0;
    WbAddr = 5'd7; WbData = 32'hAAAA_0001;
    LdAddr = 5'd7; LdData = 32'hBBBB_0002;
    for (int c = 0; c < 4 && (wb_p || ld_p); c++) begin
      WbValid = wb_p;
      LdValid = ld_p;
      #1;
      r = exp_rdy(wb_p, ld_p);
      checks++;
      if ({WbReady, LdReady} !== r)
        $display("FAIL same_addr_ready cycle %0d: got %b, want %b", c, {WbReady, LdReady}, r);
      else passed++;
      wb_go = wb_p && r[1];
      ld_go = ld_p && r[0];
      e_rw  = 1'b0;
      if (wb_go) begin
        e_rw = 1'b1; e_addr = WbAddr; e_data = WbData; ref_rf[WbAddr] = WbData;
      end else if (ld_go) begin
        e_rw = 1'b1; e_addr = LdAddr; e_data = LdData; ref_rf[LdAddr] = LdData;
      end
`ifdef REG_WR_ARB_RR_EN
      if (wb_go) m_last = 1'b0;
      else if (ld_go) m_last = 1'b1;
`endif
      if (wb_go) wb_p = 1'b0;
      if (ld_go) ld_p = 1'b0;
      @(posedge Clk);
      #1;
      checks++;
      if ({RegWrite, AddrRd, WrData} !== {e_rw, e_addr, e_data})
        $display("FAIL same_addr_write cycle %0d: got rw=%b addr=%0d data=%h, want rw=%b addr=%0d data=%h",
                 c, RegWrite, AddrRd, WrData, e_rw, e_addr, e_data);
      else passed++;
      if (RegWrite === 1'b1) begin
        tb_rf[AddrRd] = WrData;
        if (nwr == 0) first_data = WrData;
        nwr++;
      end
    end
    WbValid = 1'b0;
    LdValid = 1'b0;
    checks++;
    if (nwr !== 2) $display("FAIL same_addr_count: got %0d writes, want 2", nwr);
    else passed++;
    checks++;
    if (tb_rf[7] !== ref_rf[7])
      $display("FAIL same_addr_final: got x7=%h, want %h", tb_rf[7], ref_rf[7]);
    else passed++;
`ifndef REG_WR_ARB_RR_EN
    checks++;
    if (first_data !== 32'hAAAA_0001 || tb_rf[7] !== 32'hBBBB_0002)
      $display("FAIL same_addr_order: got first=%h x7=%h, want first=aaaa0001 x7=bbbb0002",
               first_data, tb_rf[7]);
    else passed++;
`endif
  endtask

  task automatic test_addr_zero();
    WbValid = 1'b0;
    LdValid = 1'b1;
    LdAddr  = 5'd0;
    LdData  = 32'h1234_5678;
    #1;
    checks++;
    if (LdReady !== 1'b1) $display("FAIL addr_zero_ready: got %b, want 1", LdReady);
    else passed++;
`ifdef REG_WR_ARB_RR_EN
    m_last = 1'b1;
`endif
    e_rw = 1'b0;
    @(posedge Clk);
    #1;
    LdValid = 1'b0;
    checks++;
    if ({RegWrite, AddrRd, WrData} !== {1'b0, e_addr, e_data})
      $display("FAIL addr_zero_drop: got rw=%b addr=%0d data=%h, want rw=0 addr=%0d data=%h",
               RegWrite, AddrRd, WrData, e_addr, e_data);
    else passed++;
  endtask

  task automatic test_random();
    logic              wb_p = 1'b0, ld_p = 1'b0;
    logic [ADDR_W-1:0] wa = '0, la = '0;
    logic [DATA_W-1:0] wd = '0, ldd = '0;
    logic [1:0]        r;
    logic              wb_go, ld_go;
    for (int c = 0; c < 300; c++) begin
      if (!wb_p && $urandom_range(0, 99) < 60) begin
        wb_p = 1'b1;
        wa   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        wd   = $urandom;
      end
      if (!ld_p && $urandom_range(0, 99) < 50) begin
        ld_p = 1'b1;
        la   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        ldd  = $urandom;
      end
      WbValid = wb_p; WbAddr = wa; WbData = wd;
      LdValid = ld_p; LdAddr = la; LdData = ldd;
      #1;
      r = exp_rdy(wb_p, ld_p);
      checks++;
      if ({WbReady, LdReady} !== r)
        $display("FAIL rand_ready cycle %0d: got %b, want %b", c, {WbReady, LdReady}, r);
      else passed++;
      wb_go = wb_p && r[1];
      ld_go = ld_p && r[0];
      e_rw  = 1'b0;
      if (wb_go) begin
        if (wa != 5'd0) begin e_rw = 1'b1; e_addr = wa; e_data = wd; ref_rf[wa] = wd; end
      end else if (ld_go) begin
        if (la != 5'd0) begin e_rw = 1'b1; e_addr = la; e_data = ldd; ref_rf[la] = ldd; end
      end
`ifdef REG_WR_ARB_RR_EN
      if (wb_go) m_last = 1'b0;
      else if (ld_go) m_last = 1'b1;
`endif
      if (wb_go) wb_p = 1'b0;
      if (ld_go) ld_p = 1'b0;
      @(posedge Clk);
      #1;
      checks++;
      if ({RegWrite, AddrRd, WrData, InitDone} !== {e_rw, e_addr, e_data, 1'b1})
        $display("FAIL rand_write cycle %0d: got rw=%b addr=%0d data=%h done=%b, want rw=%b addr=%0d data=%h done=1",
                 c, RegWrite, AddrRd, WrData, InitDone, e_rw, e_addr, e_data);
      else passed++;
      if (RegWrite === 1'b1) tb_rf[AddrRd] = WrData;
    end
    WbValid = 1'b0;
    LdValid = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (tb_rf[i] !== ref_rf[i])
        $display("FAIL rand_regfile x%0d: got %h, want %h", i, tb_rf[i], ref_rf[i]);
      else passed++;
    end
  endtask

`ifdef REG_WR_ARB_RR_EN
  task automatic test_rr();
    logic [ADDR_W-1:0] exp_seq [4];
    int wi = 0, li = 0;
    exp_seq[0] = 5'd10; exp_seq[1] = 5'd20; exp_seq[2] = 5'd11; exp_seq[3] = 5'd21;
    Rst_n = 1'b0;
    model_reset();
    release_reset();
    repeat (32) @(posedge Clk);
    #1;
    m_run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      WbValid = 1'b1; WbAddr = 5'(10 + wi); WbData = 32'h1000 + 32'(wi);
      LdValid = 1'b1; LdAddr = 5'(20 + li); LdData = 32'h2000 + 32'(li);
      @(posedge Clk);
      #1;
      checks++;
      if ({RegWrite, AddrRd} !== {1'b1, exp_seq[c]})
        $display("FAIL rr_alternate cycle %0d: got rw=%b addr=%0d, want rw=1 addr=%0d",
                 c, RegWrite, AddrRd, exp_seq[c]);
      else passed++;
      if (c % 2 == 0) wi++;
      else li++;
    end
    WbValid = 1'b0;
    LdValid = 1'b0;
  endtask
`endif

  task automatic test_mid_reset();
    Rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({RegWrite, AddrRd, WrData, InitDone} !== {1'b0, 5'd0, 32'd0, 1'b0})
      $display("FAIL run_reset_clear: got rw=%b addr=%0d data=%h done=%b, want all zero",
               RegWrite, AddrRd, WrData, InitDone);
    else passed++;
    release_reset();
    repeat (12) @(posedge Clk);
    #1;
    checks++;
    if ({RegWrite, AddrRd} !== {1'b1, 5'd12})
      $display("FAIL sweep_reach_12: got rw=%b addr=%0d, want rw=1 addr=12", RegWrite, AddrRd);
    else passed++;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({RegWrite, AddrRd, WrData, InitDone} !== {1'b0, 5'd0, 32'd0, 1'b0})
      $display("FAIL sweep_reset_async: got rw=%b addr=%0d data=%h done=%b, want all zero",
               RegWrite, AddrRd, WrData, InitDone);
    else passed++;
    release_reset();
    @(posedge Clk);
    #1;
    checks++;
    if ({RegWrite, AddrRd, InitDone} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL sweep_restart: got rw=%b addr=%0d done=%b, want rw=1 addr=1 done=0",
               RegWrite, AddrRd, InitDone);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init_sweep();
    test_wb_single();
    test_same_addr();
    test_addr_zero();
    test_random();
`ifdef REG_WR_ARB_RR_EN
    test_rr();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
